mem_port_arbiter: RTL

Shares the core's single external memory port between the instruction-fetch requester (IF) and the load/store requester (LS). It uses valid/ready request channels and one-cycle response pulses. It sits between the CPU datapath's `instr_raddr`/`data_raddr`/`data_waddr`/`mem_wen` side and a memory that may stall and respond with variable latency. At most one transaction is outstanding. The block arbitrates, latches the winning request, issues it, waits for the response and routes it back to the owner.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/LS requesters, the arbiter and the external memory port.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [AW-1:0]     if_req_addr;
    logic              if_resp_valid;
    logic [DW-1:0]     if_resp_data;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [AW-1:0]     ls_req_addr;
    logic              ls_req_wen;
    logic [DW-1:0]     ls_req_wdata;
    logic [DW/8-1:0]   ls_req_wmask;
    logic              ls_resp_valid;
    logic [DW-1:0]     ls_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_wen;
    logic [DW-1:0]     mem_req_wdata;
    logic [DW/8-1:0]   mem_req_wmask;
    logic              mem_resp_valid;
    logic [DW-1:0]     mem_resp_data;

    modport master (
        input  if_req_valid, if_req_addr,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output if_req_ready, if_resp_valid, if_resp_data,
        output ls_req_ready, ls_resp_valid, ls_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );

    modport slave (
        output if_req_valid, if_req_addr,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  ls_req_ready, ls_resp_valid, ls_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS), one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LS-over-IF priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus,
    output logic                err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t            state_reg;
    logic              owner_reg;
    logic [AW-1:0]     addr_reg;
    logic              wen_reg;
    logic [DW-1:0]     wdata_reg;
    logic [DW/8-1:0]   wmask_reg;
    logic              mem_req_valid_reg;
    logic [CW-1:0]     cnt_reg;

    logic              grant_ls;
    logic              grant_if;
    logic              in_idle;
    logic              in_wait;
    logic              timeout_hit;
    logic              resp_fire;
    logic [DW-1:0]     resp_data;

`ifdef MEM_ARB_RR_EN
    // Last-grant pointer: 1 = LS won the previous accept. Ties go to the other side.
    logic last_ls_reg;

    always_comb begin
        grant_ls = bus.ls_req_valid && (!bus.if_req_valid || !last_ls_reg);
        grant_if = bus.if_req_valid && !grant_ls;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls_reg <= 1'b0;
        end else if (in_idle && (grant_ls || grant_if)) begin
            last_ls_reg <= grant_ls;
        end
    end
`else
    assign grant_ls = bus.ls_req_valid;
    assign grant_if = bus.if_req_valid && !bus.ls_req_valid;
`endif

    assign in_idle = (state_reg == ST_IDLE);
    assign in_wait = (state_reg == ST_WAIT);

    assign bus.ls_req_ready = in_idle && grant_ls;
    assign bus.if_req_ready = in_idle && grant_if;

    // A real response in the final WAIT cycle takes precedence over the abort.
    assign timeout_hit = in_wait && !bus.mem_resp_valid && (cnt_reg == TIMEOUT_CNT);
    assign resp_fire   = in_wait && (bus.mem_resp_valid || timeout_hit);
    assign resp_data   = bus.mem_resp_valid ? bus.mem_resp_data : '0;
    assign err         = timeout_hit;

    assign bus.if_resp_valid = resp_fire && (owner_reg == OWNER_IF);
    assign bus.ls_resp_valid = resp_fire && (owner_reg == OWNER_LS);
    assign bus.if_resp_data  = bus.if_resp_valid ? resp_data : '0;
    assign bus.ls_resp_data  = bus.ls_resp_valid ? resp_data : '0;

    assign bus.mem_req_valid = mem_req_valid_reg;
    assign bus.mem_req_addr  = addr_reg;
    assign bus.mem_req_wen   = wen_reg;
    assign bus.mem_req_wdata = wdata_reg;
    assign bus.mem_req_wmask = wmask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            owner_reg         <= OWNER_IF;
            addr_reg          <= '0;
            wen_reg           <= 1'b0;
            wdata_reg         <= '0;
            wmask_reg         <= '0;
            mem_req_valid_reg <= 1'b0;
            cnt_reg           <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_ls) begin
                        addr_reg          <= bus.ls_req_addr;
                        wen_reg           <= bus.ls_req_wen;
                        wdata_reg         <= bus.ls_req_wdata;
                        wmask_reg         <= bus.ls_req_wmask;
                        owner_reg         <= OWNER_LS;
                        mem_req_valid_reg <= 1'b1;
                        state_reg         <= ST_ISSUE;
                    end else if (grant_if) begin
                        addr_reg          <= bus.if_req_addr;
                        wen_reg           <= 1'b0;
                        wdata_reg         <= '0;
                        wmask_reg         <= '0;
                        owner_reg         <= OWNER_IF;
                        mem_req_valid_reg <= 1'b1;
                        state_reg         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_reg <= 1'b0;
                        cnt_reg           <= '0;
                        state_reg         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_resp_valid || timeout_hit) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg         <= ST_IDLE;
                    mem_req_valid_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule
